// File: rtl/memory_responder_pkg.sv
// Shared typedefs for the CPU memory interface: word size, access flags and responder states.
`ifndef REGSIZE
`define REGSIZE 8
`endif

package typedef_collection;
  typedef logic [`REGSIZE-1:0] DEFAULT_TYPE;

  typedef enum logic [1:0] {
    MEMORY_STAY  = 2'd0,
    MEMORY_READ  = 2'd1,
    MEMORY_WRITE = 2'd2
  } MEMORY_FLAG_TYPE;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_SERVE = 1'b1
  } MEMORY_UNIT_STATE_TYPE;
endpackage

// File: rtl/memory_array.sv
// DEPTH x WIDTH word storage: one synchronous write port, one asynchronous read port, no reset.
module memory_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts a program image over the load port while holding the CPU in
// reset, then serves CPU reads/writes. Optional output port enabled by MEMORY_MMIO_OUT_EN.
// Load port handshake: a word transfers at a posedge where load_valid && load_ready; the loader
// must hold the word stable while load_valid is high and load_ready is low.
`ifndef REGSIZE
`define REGSIZE 8
`endif

module memory_responder
  import typedef_collection::*;
#(
  parameter int                  DEPTH     = 256,
  parameter logic [`REGSIZE-1:0] MMIO_ADDR = 8'hFF
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic [`REGSIZE-1:0]   address,
  input  MEMORY_FLAG_TYPE       rw_flag,
  input  logic [`REGSIZE-1:0]   write_memory_value,
  output logic [`REGSIZE-1:0]   read_memory_value,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [`REGSIZE-1:0]   load_address,
  input  logic [`REGSIZE-1:0]   load_data,
  input  logic                  load_last,
  output logic                  cpu_hold,
  output logic                  range_error,
`ifdef MEMORY_MMIO_OUT_EN
  output logic [`REGSIZE-1:0]   mmio_out,
`endif
  output logic                  state_dbg
);
  localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CW      = `REGSIZE + 1;
  localparam logic [CW-1:0]     DEPTH_W = CW'(DEPTH);

  MEMORY_UNIT_STATE_TYPE state_q, state_d;
  DEFAULT_TYPE           hold_q, hold_d;
  logic                  range_err_q, range_err_d;
  DEFAULT_TYPE           mmio_q, mmio_d;

  logic                  serve, is_read, is_write, cpu_in_range, load_in_range, mmio_hit;
  logic                  arr_we;
  logic [AW-1:0]         arr_waddr;
  DEFAULT_TYPE           arr_wdata, arr_rdata;

  memory_array #(.DEPTH(DEPTH), .WIDTH(`REGSIZE), .AW(AW)) u_array (
    .clk   (CLOCK),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (address[AW-1:0]),
    .rdata (arr_rdata)
  );

  always_comb begin
    serve         = (state_q == MEM_SERVE);
    is_read       = (rw_flag == MEMORY_READ);
    is_write      = (rw_flag == MEMORY_WRITE);
    cpu_in_range  = ({1'b0, address} < DEPTH_W);
    load_in_range = ({1'b0, load_address} < DEPTH_W);
`ifdef MEMORY_MMIO_OUT_EN
    mmio_hit      = serve && (address == MMIO_ADDR);
`else
    mmio_hit      = 1'b0;
`endif
  end

  always_comb begin
    state_d           = state_q;
    range_err_d       = range_err_q;
    mmio_d            = mmio_q;
    arr_we            = 1'b0;
    arr_waddr         = load_address[AW-1:0];
    arr_wdata         = load_data;
    read_memory_value = hold_q;
    load_ready        = 1'b0;
    cpu_hold          = 1'b0;

    case (state_q)
      MEM_LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) begin
          if (load_in_range) arr_we = 1'b1;
          else               range_err_d = 1'b1;
          if (load_last) state_d = MEM_SERVE;
        end
      end
      default: begin
        arr_waddr = address[AW-1:0];
        arr_wdata = write_memory_value;
        // The output port shadows the array: neither reads nor writes to it touch storage.
        if (is_read) begin
          if (mmio_hit)          read_memory_value = mmio_q;
          else if (cpu_in_range) read_memory_value = arr_rdata;
          else                   read_memory_value = '0;
        end
        if (is_write) begin
          if (mmio_hit)          mmio_d = write_memory_value;
          else if (cpu_in_range) arr_we = 1'b1;
        end
        if ((is_read || is_write) && !cpu_in_range && !mmio_hit) range_err_d = 1'b1;
      end
    endcase

    // Capturing the visible value keeps the data stable through MEMORY_STAY cycles.
    hold_d = read_memory_value;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= MEM_LOAD;
      hold_q      <= '0;
      range_err_q <= 1'b0;
      mmio_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      range_err_q <= range_err_d;
      mmio_q      <= mmio_d;
    end
  end

  assign range_error = range_err_q;
  assign state_dbg   = serve;
`ifdef MEMORY_MMIO_OUT_EN
  assign mmio_out    = mmio_q;
`endif
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder (DEPTH=16): reset, load, serve table, randomized traffic vs. model.
`ifndef REGSIZE
`define REGSIZE 8
`endif

module tb_memory_responder;
  import typedef_collection::*;

  localparam int         DEPTH = 16;
  localparam logic [7:0] MMIO  = 8'h0F;

  logic            CLOCK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [7:0]      address = '0;
  MEMORY_FLAG_TYPE rw_flag = MEMORY_STAY;
  logic [7:0]      write_memory_value = '0;
  logic [7:0]      read_memory_value;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [7:0]      load_address = '0;
  logic [7:0]      load_data = '0;
  logic            load_last = 1'b0;
  logic            cpu_hold;
  logic            range_error;
  logic            state_dbg;
`ifdef MEMORY_MMIO_OUT_EN
  logic [7:0]      mmio_out;
`endif

  memory_responder #(.DEPTH(DEPTH), .MMIO_ADDR(MMIO)) dut (
    .CLOCK              (CLOCK),
    .RESET_N            (RESET_N),
    .address            (address),
    .rw_flag            (rw_flag),
    .write_memory_value (write_memory_value),
    .read_memory_value  (read_memory_value),
    .load_valid         (load_valid),
    .load_ready         (load_ready),
    .load_address       (load_address),
    .load_data          (load_data),
    .load_last          (load_last),
    .cpu_hold           (cpu_hold),
    .range_error        (range_error),
`ifdef MEMORY_MMIO_OUT_EN
    .mmio_out           (mmio_out),
`endif
    .state_dbg          (state_dbg)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents with per-word "known" flags plus the visible registers.
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  bit         m_serve = 0;
  logic [7:0] m_hold = '0;
  bit         m_hold_known = 1;
  bit         m_re = 0;
  logic [7:0] m_mmio = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_serve = 0; m_hold = '0; m_hold_known = 1; m_re = 0; m_mmio = '0;
  endtask

  // One cycle: drive at negedge, check outputs against the model, then advance the model
  // to reflect the coming posedge.
  task automatic do_cycle(input logic [1:0] f, input logic [7:0] a, input logic [7:0] wd,
                          input bit lv, input logic [7:0] la, input logic [7:0] ld, input bit ll);
    logic [7:0] e_rd;
    bit e_known, hit;
    @(negedge CLOCK);
    rw_flag = MEMORY_FLAG_TYPE'(f); address = a; write_memory_value = wd;
    load_valid = lv; load_address = la; load_data = ld; load_last = ll;
    #1;
    hit = 0;
`ifdef MEMORY_MMIO_OUT_EN
    hit = m_serve && (a == MMIO);
`endif
    if (m_serve && f == 2'd1) begin
      if (hit)                   begin e_rd = m_mmio; e_known = 1; end
      else if (int'(a) < DEPTH)  begin e_rd = m_mem[a[3:0]]; e_known = m_known[a[3:0]]; end
      else                       begin e_rd = 8'h00; e_known = 1; end
    end else begin
      e_rd = m_hold; e_known = m_hold_known;
    end
    if (e_known) chk("model_rd", 32'(read_memory_value), 32'(e_rd));
    chk("model_ready", 32'(load_ready), 32'(!m_serve));
    chk("model_hold", 32'(cpu_hold), 32'(!m_serve));
    chk("model_range", 32'(range_error), 32'(m_re));
`ifdef MEMORY_MMIO_OUT_EN
    chk("model_mmio", 32'(mmio_out), 32'(m_mmio));
`endif
    if (!m_serve) begin
      if (lv) begin
        if (int'(la) < DEPTH) begin m_mem[la[3:0]] = ld; m_known[la[3:0]] = 1; end
        else m_re = 1;
        if (ll) m_serve = 1;
      end
    end else begin
      if (f == 2'd2) begin
        if (hit) m_mmio = wd;
        else if (int'(a) < DEPTH) begin m_mem[a[3:0]] = wd; m_known[a[3:0]] = 1; end
        else m_re = 1;
      end
      if (f == 2'd1 && !hit && int'(a) >= DEPTH) m_re = 1;
    end
    m_hold = e_rd; m_hold_known = e_known;
  endtask

  typedef struct {
    logic [1:0] f; logic [7:0] a; logic [7:0] wd;
    bit lv; logic [7:0] la; logic [7:0] ld;
    logic [7:0] exp_rd; bit exp_re;
  } vec_t;

  typedef struct { bit lv; logic [7:0] la; logic [7:0] ld; bit ll; } load_t;

  initial begin
    vec_t  tbl [15];
    load_t ld_tbl [5];

    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // Reset asserted from time zero during a READ of address 3: outputs settle with no edge.
    rw_flag = MEMORY_READ; address = 8'd3;
    #3;
    chk("rst_rd", 32'(read_memory_value), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_range", 32'(range_error), 32'h0);
    @(negedge CLOCK); RESET_N = 1'b1;

    // Program image with one idle cycle between words; rw_flag=READ is ignored while loading.
    ld_tbl[0] = '{1, 8'd0, 8'h03, 0};
    ld_tbl[1] = '{0, 8'd0, 8'h00, 0};
    ld_tbl[2] = '{1, 8'd1, 8'h05, 0};
    ld_tbl[3] = '{0, 8'd0, 8'h00, 0};
    ld_tbl[4] = '{1, 8'd2, 8'hF0, 1};
    for (int i = 0; i < 5; i++) begin
      do_cycle(2'd1, 8'd1, 8'h00, ld_tbl[i].lv, ld_tbl[i].la, ld_tbl[i].ld, ld_tbl[i].ll);
      chk("load_ready", 32'(load_ready), 32'h1);
      chk("load_rd_held", 32'(read_memory_value), 32'h0);
    end

    tbl[0]  = '{2'd1, 8'd1,  8'h00, 0, 8'd0, 8'h00, 8'h05, 0};
    tbl[1]  = '{2'd1, 8'd0,  8'h00, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[2]  = '{2'd0, 8'd0,  8'h00, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[3]  = '{2'd0, 8'd0,  8'h00, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[4]  = '{2'd3, 8'd1,  8'h00, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[5]  = '{2'd2, 8'd12, 8'hAA, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[6]  = '{2'd1, 8'd12, 8'h00, 0, 8'd0, 8'h00, 8'hAA, 0};
    tbl[7]  = '{2'd0, 8'd0,  8'h00, 1, 8'd0, 8'h77, 8'hAA, 0};
    tbl[8]  = '{2'd1, 8'd0,  8'h00, 1, 8'd0, 8'h77, 8'h03, 0};
    tbl[9]  = '{2'd2, 8'd20, 8'h11, 0, 8'd0, 8'h00, 8'h03, 0};
    tbl[10] = '{2'd1, 8'd20, 8'h00, 0, 8'd0, 8'h00, 8'h00, 1};
    tbl[11] = '{2'd0, 8'd0,  8'h00, 0, 8'd0, 8'h00, 8'h00, 1};
    tbl[12] = '{2'd2, MMIO,  8'h5A, 0, 8'd0, 8'h00, 8'h00, 1};
    tbl[13] = '{2'd1, MMIO,  8'h00, 0, 8'd0, 8'h00, 8'h5A, 1};
    tbl[14] = '{2'd0, 8'd0,  8'h00, 0, 8'd0, 8'h00, 8'h5A, 1};
    for (int i = 0; i < 15; i++) begin
      do_cycle(tbl[i].f, tbl[i].a, tbl[i].wd, tbl[i].lv, tbl[i].la, tbl[i].ld, 1'b0);
      chk($sformatf("tbl%0d_rd", i), 32'(read_memory_value), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_range", i), 32'(range_error), 32'(tbl[i].exp_re));
      chk($sformatf("tbl%0d_ready", i), 32'(load_ready), 32'h0);
      chk($sformatf("tbl%0d_hold", i), 32'(cpu_hold), 32'h0);
    end
`ifdef MEMORY_MMIO_OUT_EN
    chk("mmio_out", 32'(mmio_out), 32'h5A);
`endif

    // Randomized CPU traffic with loader noise; mostly in-range addresses, some beyond DEPTH.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) :
           (($urandom_range(0, 7) == 0) ? MMIO : 8'($urandom_range(0, DEPTH - 1)));
      do_cycle(2'($urandom_range(0, 3)), ra, 8'($urandom), 1'($urandom),
               8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
    end

    // Reset mid-read: immediate effect, array contents survive.
    @(negedge CLOCK);
    rw_flag = MEMORY_READ; address = 8'd1;
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(read_memory_value), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'h1);
    chk("mid_rst_hold", 32'(cpu_hold), 32'h1);
    chk("mid_rst_range", 32'(range_error), 32'h0);
    model_reset();
    @(negedge CLOCK); RESET_N = 1'b1;

    // Reload: out-of-range loader word sets range_error; then a last word to address 5.
    do_cycle(2'd0, 8'd0, 8'h00, 1, 8'd20, 8'h33, 0);
    do_cycle(2'd0, 8'd0, 8'h00, 1, 8'd5,  8'h99, 1);
    chk("reload_range", 32'(range_error), 32'h1);
    do_cycle(2'd1, 8'd5, 8'h00, 0, 8'd0, 8'h00, 0);
    chk("reload_rd5", 32'(read_memory_value), 32'h99);
    chk("reload_served", 32'(cpu_hold), 32'h0);
    for (int i = 0; i < DEPTH; i++) do_cycle(2'd1, 8'(i), 8'h00, 0, 8'd0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
